// File: rtl/led_pattern_writer_if.sv
// Write port of the dual-port LED pattern RAM.
// The pattern writer drives it as master; the RAM write side is the slave.
interface led_pattern_writer_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  modport master (output ram_we, output ram_addr, output ram_wdata);
  modport slave  (input  ram_we, input  ram_addr, input  ram_wdata);
endinterface

// File: rtl/led_pattern_writer.sv
// Debounces the write/clear push-buttons and fills the LED pattern RAM:
// one word per accepted write press, or a full zero sweep per clear press.
module led_pattern_writer #(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DATA_WIDTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  btn_wr_n,
  input  logic                  btn_clr_n,
  input  logic [DATA_WIDTH-1:0] sw_data,
  led_pattern_writer_if.master  ram_if,
  output logic [ADDR_WIDTH:0]   pat_len,
  output logic                  full,
  output logic                  busy
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  // Button bit 0 = write, bit 1 = clear.
  logic [1:0]                  btn_s1_q, btn_s2_q;
  logic [DATA_WIDTH-1:0]       sw_s1_q, sw_s2_q;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]                  acc_q, acc_d, acc_prev_q, press_q;

  state_t                      state_q;
  logic [ADDR_WIDTH-1:0]       ptr_q;
  logic [LEN_W-1:0]            pat_len_q;
  logic [LEN_W-1:0]            len_inc;
  logic                        full_q, busy_q;
  logic                        ram_we_q;
  logic [ADDR_WIDTH-1:0]       ram_addr_q;
  logic [DATA_WIDTH-1:0]       ram_wdata_q;

  // Two-flop synchronizers; buttons reset to the released level.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q <= 2'b11;
      btn_s2_q <= 2'b11;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= {btn_clr_n, btn_wr_n};
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_data;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d = '0;
    acc_d = acc_q;
    for (int b = 0; b < 2; b++) begin
      if (btn_s2_q[b] != acc_q[b]) begin
        if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          acc_d[b] = btn_s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      acc_q      <= 2'b11;
      acc_prev_q <= 2'b11;
      press_q    <= 2'b00;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      press_q    <= acc_prev_q & ~acc_q;
    end
  end

  assign len_inc = pat_len_q + LEN_W'(1);

  // Clear has priority over write; events outside IDLE are dropped.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      pat_len_q   <= '0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_q[1]) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
          end else if (press_q[0] && !full_q) begin
            state_q     <= WRITE;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= ptr_q;
            ram_wdata_q <= sw_s2_q;
          end
        end
        WRITE: begin
          ptr_q     <= ptr_q + ADDR_WIDTH'(1);
          pat_len_q <= len_inc;
          full_q    <= (len_inc == LEN_W'(DEPTH));
          state_q   <= IDLE;
        end
        CLEAR: begin
          if (ram_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
            ptr_q     <= '0;
            pat_len_q <= '0;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_if.ram_we    = ram_we_q;
  assign ram_if.ram_addr  = ram_addr_q;
  assign ram_if.ram_wdata = ram_wdata_q;
  assign pat_len          = pat_len_q;
  assign full             = full_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_led_pattern_writer.sv
// Directed + randomized bench for led_pattern_writer against a press-level
// model of the pattern store (list of stored words, expected RAM writes).
module tb_led_pattern_writer;
  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 4;
  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_wr_n, btn_clr_n;
  logic [DW-1:0] sw_data;
  logic [AW:0]   pat_len;
  logic          full, busy;

  led_pattern_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

  led_pattern_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_i    (clk),
    .rst_n    (rst_n),
    .btn_wr_n (btn_wr_n),
    .btn_clr_n(btn_clr_n),
    .sw_data  (sw_data),
    .ram_if   (rif),
    .pat_len  (pat_len),
    .full     (full),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed write-port activity and a behavioural RAM on the write port.
  logic [AW+DW-1:0] q_obs[$];
  int               obs_busy = 0;
  logic [DW-1:0]    tb_ram [DEPTH];

  always @(negedge clk) begin
    if (rif.ram_we === 1'b1) q_obs.push_back({rif.ram_addr, rif.ram_wdata});
    if (busy === 1'b1) obs_busy <= obs_busy + 1;
  end

  always @(posedge clk) begin
    if (rif.ram_we === 1'b1) tb_ram[rif.ram_addr] <= rif.ram_wdata;
  end

  // Model: stored words in press order, expected writes, expected busy cycles.
  logic [AW+DW-1:0] q_exp[$];
  logic [DW-1:0]    m_mem [DEPTH];
  int               m_len  = 0;
  int               m_busy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [DW-1:0] v);
    if (m_len < DEPTH) begin
      q_exp.push_back({AW'(m_len), v});
      m_mem[m_len] = v;
      m_len++;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      q_exp.push_back({AW'(i), DW'(0)});
      m_mem[i] = '0;
    end
    m_len  = 0;
    m_busy = m_busy + DEPTH;
  endtask

  task automatic check_step(input string tag);
    logic [AW+DW-1:0] e, o;
    chk({tag, "/nwrites"}, q_obs.size(), q_exp.size());
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      chk({tag, "/write"}, 32'(o), 32'(e));
    end
    while (q_exp.size() > 0) void'(q_exp.pop_front());
    while (q_obs.size() > 0) void'(q_obs.pop_front());
    chk({tag, "/busycyc"}, obs_busy, m_busy);
    chk({tag, "/pat_len"}, 32'(pat_len), m_len);
    chk({tag, "/full"}, 32'(full), 32'(m_len == DEPTH));
    chk({tag, "/busy"}, 32'(busy), 0);
    for (int i = 0; i < m_len; i++) chk({tag, "/ram"}, 32'(tb_ram[i]), 32'(m_mem[i]));
  endtask

  task automatic press(input logic do_wr, input logic do_clr, input logic [DW-1:0] v, input int hold);
    @(negedge clk);
    sw_data = v;
    if (do_wr)  btn_wr_n  = 1'b0;
    if (do_clr) btn_clr_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_wr_n  = 1'b1;
    btn_clr_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "/we"}, 32'(rif.ram_we), 0);
    chk({tag, "/addr"}, 32'(rif.ram_addr), 0);
    chk({tag, "/wdata"}, 32'(rif.ram_wdata), 0);
    chk({tag, "/pat_len"}, 32'(pat_len), 0);
    chk({tag, "/full"}, 32'(full), 0);
    chk({tag, "/busy"}, 32'(busy), 0);
  endtask

  initial begin
    int            lat, len_rise, len_after;
    bit            found;
    logic [DW-1:0] v;
    logic [DW-1:0] fill_vals [DEPTH];

    rst_n     = 1'b0;
    btn_wr_n  = 1'b1;
    btn_clr_n = 1'b1;
    sw_data   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Write latency: first sampling edge is e=0, write pulse expected at e=DB+3.
    @(negedge clk);
    sw_data  = 4'hA;
    btn_wr_n = 1'b0;
    model_write(4'hA);
    lat = -1; len_rise = -1; len_after = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (rif.ram_we === 1'b1 && lat < 0) begin
        lat      = e;
        len_rise = int'(pat_len);
      end else if (lat >= 0 && e == lat + 1) begin
        len_after = int'(pat_len);
      end
    end
    chk("latency", lat, DB + 3);
    chk("len_at_pulse", len_rise, 0);
    chk("len_after_pulse", len_after, 1);
    @(negedge clk);
    btn_wr_n = 1'b1;
    repeat (20) @(negedge clk);
    check_step("write1");

    // Bounce: toggling every 2 cycles, then random glitches shorter than DB.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i % 2 == 0) btn_wr_n = ~btn_wr_n;
    end
    btn_wr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_wr_n = 1'b0;
      repeat ($urandom_range(1, DB - 1)) @(negedge clk);
      btn_wr_n = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_step("bounce");

    press(1'b0, 1'b1, 4'h0, 12);
    model_clear();
    check_step("clear1");

    // Fill to full, then one dropped press.
    fill_vals[0] = 4'h1; fill_vals[1] = 4'h2; fill_vals[2] = 4'h4; fill_vals[3] = 4'h8;
    for (int i = 0; i < DEPTH; i++) begin
      press(1'b1, 1'b0, fill_vals[i], $urandom_range(8, 14));
      model_write(fill_vals[i]);
      check_step("fill");
    end
    v = DW'($urandom);
    press(1'b1, 1'b0, v, 10);
    model_write(v);
    check_step("full_drop");

    press(1'b0, 1'b1, 4'h0, 10);
    model_clear();
    check_step("clear_full");
    press(1'b1, 1'b0, 4'h5, 10);
    model_write(4'h5);
    check_step("after_clear");

    press(1'b1, 1'b1, 4'hF, 15);
    model_clear();
    check_step("simultaneous");

    // Write press whose event lands inside the clear sweep.
    @(negedge clk);
    btn_clr_n = 1'b0;
    repeat (2) @(negedge clk);
    sw_data  = 4'h3;
    btn_wr_n = 1'b0;
    repeat (13) @(negedge clk);
    btn_wr_n  = 1'b1;
    btn_clr_n = 1'b1;
    repeat (20) @(negedge clk);
    model_clear();
    check_step("write_during_busy");

    // Random mix of presses.
    for (int i = 0; i < 10; i++) begin
      v = DW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        press(1'b0, 1'b1, v, $urandom_range(8, 14));
        model_clear();
      end else begin
        press(1'b1, 1'b0, v, $urandom_range(8, 14));
        model_write(v);
      end
      check_step("random");
    end

    // Reset in the middle of a clear sweep, at address 2.
    @(negedge clk);
    btn_clr_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (rif.ram_we === 1'b1 && rif.ram_addr == AW'(2)) found = 1'b1;
    end
    chk("reach_addr2", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_clear_reset");
    btn_clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q_exp.push_back({AW'(i), DW'(0)});
      m_mem[i] = '0;
    end
    m_len  = 0;
    m_busy = m_busy + 3;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    press(1'b1, 1'b0, 4'h9, 10);
    model_write(4'h9);
    check_step("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
